// File: rtl/pipeline_to_pulse_if.sv
// Handshake bundle between a ready/valid producer, the pulse wrapper and the
// non-pipelined module it drives.
interface pipeline_to_pulse_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  valid_in;
  logic                  ready_in;
  logic [WORD_WIDTH-1:0] data_in;
  logic [WORD_WIDTH-1:0] module_data_in;
  logic                  module_data_in_valid;
  logic                  module_ready;
  logic                  busy;

  modport slave (
    input  valid_in, data_in, module_ready,
    output ready_in, module_data_in, module_data_in_valid, busy
  );

  modport master (
    output valid_in, data_in, module_ready,
    input  ready_in, module_data_in, module_data_in_valid, busy
  );
endinterface

// File: rtl/pipeline_to_pulse.sv
// Converts a ready/valid input stream into one-cycle start pulses for a module
// with initiation interval > 1, holding each issued word until module_ready.
module pipeline_to_pulse #(
  parameter int WORD_WIDTH = 8
) (
  input  logic              clock,
  input  logic              clear,
  pipeline_to_pulse_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [WORD_WIDTH-1:0] buf_mem [0:1];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;
  logic [1:0]            count_next;
  logic [0:0]            state_reg;
  logic [0:0]            state_next;
  logic                  ready_reg;
  logic                  pulse_reg;
  logic [WORD_WIDTH-1:0] data_reg;

  logic head_valid;
  logic push;
  logic issue;

  // Issue looks only at the registered buffer, so a word never bypasses it.
  assign head_valid = (count_reg != 2'd0);
  assign push       = bus.valid_in && ready_reg;
  assign issue      = head_valid && ((state_reg == IDLE) || bus.module_ready);

  always_comb begin
    count_next = count_reg + {1'b0, push} - {1'b0, issue};
  end

  always_comb begin
    state_next = state_reg;
    if (issue) begin
      state_next = BUSY;
    end else if ((state_reg == BUSY) && bus.module_ready) begin
      state_next = IDLE;
    end
  end

  // Storage carries no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_mem[wr_ptr_reg] <= bus.data_in;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      state_reg  <= IDLE;
      ready_reg  <= 1'b0;
      pulse_reg  <= 1'b0;
      data_reg   <= '0;
    end else begin
      count_reg <= count_next;
      state_reg <= state_next;
      ready_reg <= (count_next < 2'd2);
      pulse_reg <= issue;
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (issue) begin
        data_reg   <= buf_mem[rd_ptr_reg];
        rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

  assign bus.ready_in             = ready_reg;
  assign bus.module_data_in       = data_reg;
  assign bus.module_data_in_valid = pulse_reg;
  assign bus.busy                 = (state_reg == BUSY);

endmodule

// File: tb/tb_pipeline_to_pulse.sv
// Scoreboard bench for pipeline_to_pulse: accepted words are queued and
// compared against each start pulse; a small responder emulates the module.
module tb_pipeline_to_pulse;
  localparam int W = 8;

  logic clock = 1'b0;
  logic clear = 1'b1;

  pipeline_to_pulse_if #(.WORD_WIDTH(W)) ifc ();

  pipeline_to_pulse #(.WORD_WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (ifc)
  );

  always #5 clock = ~clock;

  logic auto_mr = 1'b0;
  logic man_mr  = 1'b0;
  assign ifc.module_ready = auto_mr | man_mr;

  logic [W-1:0] sb [$];
  int           n_checks    = 0;
  int           n_pass      = 0;
  int           pulse_count = 0;
  int           base        = 0;
  logic         prev_pulse  = 1'b0;
  logic [W-1:0] last_issued = '0;
  logic         auto_en     = 1'b0;
  int           ready_delay = 1;
  int           cd          = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a falling edge; returns at the falling edge after the word is taken.
  task automatic drive_word(input logic [W-1:0] d);
    int waited = 0;
    ifc.valid_in = 1'b1;
    ifc.data_in  = d;
    while (!ifc.ready_in && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check("push_ready", {31'd0, ifc.ready_in}, 32'd1);
    if (ifc.ready_in) begin
      sb.push_back(d);
      $display("push   data=0x%02h", d);
    end
    @(negedge clock);
    ifc.valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((sb.size() != 0 || ifc.busy) && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    check("drain_busy", {31'd0, ifc.busy}, 32'd0);
    check("drain_sb", sb.size(), 32'd0);
  endtask

  // Monitor and module emulation, both away from the active edge.
  always @(negedge clock) begin
    if (ifc.module_data_in_valid) begin
      pulse_count++;
      $display("pulse  data=0x%02h", ifc.module_data_in);
      check("pulse_width", {31'd0, prev_pulse}, 32'd0);
      check("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) check("pulse_data", ifc.module_data_in, sb.pop_front());
      last_issued = ifc.module_data_in;
    end else if (ifc.busy) begin
      check("data_hold", ifc.module_data_in, last_issued);
    end
    prev_pulse = ifc.module_data_in_valid;

    auto_mr = 1'b0;
    if (!auto_en) begin
      cd = -1;
    end else begin
      if (cd == 0) begin
        auto_mr = 1'b1;
        cd = -1;
      end else if (cd > 0) begin
        cd--;
      end
      if (ifc.module_data_in_valid) cd = ready_delay - 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.valid_in = 1'b0;
    ifc.data_in  = '0;

    // Reset state and release
    repeat (2) @(negedge clock);
    check("rst_ready", {31'd0, ifc.ready_in}, 32'd0);
    check("rst_busy", {31'd0, ifc.busy}, 32'd0);
    check("rst_valid", {31'd0, ifc.module_data_in_valid}, 32'd0);
    check("rst_data", ifc.module_data_in, 32'd0);
    clear = 1'b0;
    @(negedge clock);
    check("ready_after_release", {31'd0, ifc.ready_in}, 32'd1);

    // Single word, module_ready 3 cycles after the pulse
    auto_en = 1'b1;
    ready_delay = 3;
    drive_word(8'hA5);
    check("no_bypass_valid", {31'd0, ifc.module_data_in_valid}, 32'd0);
    check("no_bypass_busy", {31'd0, ifc.busy}, 32'd0);
    @(negedge clock);
    check("single_pulse", {31'd0, ifc.module_data_in_valid}, 32'd1);
    check("single_busy", {31'd0, ifc.busy}, 32'd1);
    repeat (2) begin
      @(negedge clock);
      check("single_busy_wait", {31'd0, ifc.busy}, 32'd1);
      check("single_no_repulse", {31'd0, ifc.module_data_in_valid}, 32'd0);
    end
    wait_idle();
    check("single_hold_after", ifc.module_data_in, 32'hA5);

    // Back-to-back stream, module_ready one cycle after each pulse
    ready_delay = 1;
    base = pulse_count;
    drive_word(8'h01);
    drive_word(8'h02);
    drive_word(8'h03);
    wait_idle();
    check("b2b_count", pulse_count - base, 32'd3);

    // Backpressure: module_ready withheld while valid_in stays high
    auto_en = 1'b0;
    @(negedge clock);
    base = pulse_count;
    ifc.valid_in = 1'b1;
    ifc.data_in  = 8'h10;
    check("bp_ready0", {31'd0, ifc.ready_in}, 32'd1);
    sb.push_back(8'h10);
    @(negedge clock);
    ifc.data_in = 8'h11;
    check("bp_ready1", {31'd0, ifc.ready_in}, 32'd1);
    sb.push_back(8'h11);
    @(negedge clock);
    ifc.data_in = 8'h12;
    check("bp_ready2", {31'd0, ifc.ready_in}, 32'd1);
    sb.push_back(8'h12);
    @(negedge clock);
    ifc.data_in = 8'h13;
    repeat (10) @(negedge clock);
    check("bp_full", {31'd0, ifc.ready_in}, 32'd0);
    check("bp_busy", {31'd0, ifc.busy}, 32'd1);
    check("bp_one_issued", pulse_count - base, 32'd1);
    man_mr = 1'b1;
    @(negedge clock);
    man_mr = 1'b0;
    check("bp_issue_same_edge", {31'd0, ifc.module_data_in_valid}, 32'd1);
    check("bp_issue_data", ifc.module_data_in, 32'h11);
    check("bp_ready_back", {31'd0, ifc.ready_in}, 32'd1);
    sb.push_back(8'h13);
    @(negedge clock);
    ifc.valid_in = 1'b0;
    repeat (3) begin
      repeat (2) @(negedge clock);
      man_mr = 1'b1;
      @(negedge clock);
      man_mr = 1'b0;
    end
    @(negedge clock);
    check("bp_count", pulse_count - base, 32'd4);
    check("bp_idle", {31'd0, ifc.busy}, 32'd0);

    // Spurious module_ready while idle and empty
    base = pulse_count;
    man_mr = 1'b1;
    @(negedge clock);
    man_mr = 1'b0;
    check("spur_busy", {31'd0, ifc.busy}, 32'd0);
    check("spur_valid", {31'd0, ifc.module_data_in_valid}, 32'd0);
    repeat (3) @(negedge clock);
    check("spur_count", pulse_count - base, 32'd0);

    // Clear while busy with two words buffered
    ifc.valid_in = 1'b1;
    ifc.data_in  = 8'h20;
    sb.push_back(8'h20);
    @(negedge clock);
    ifc.data_in = 8'h21;
    sb.push_back(8'h21);
    @(negedge clock);
    ifc.data_in = 8'h22;
    sb.push_back(8'h22);
    @(negedge clock);
    ifc.valid_in = 1'b0;
    check("clr_pre_busy", {31'd0, ifc.busy}, 32'd1);
    check("clr_pre_full", {31'd0, ifc.ready_in}, 32'd0);
    #2 clear = 1'b1;
    #1;
    check("clr_async_ready", {31'd0, ifc.ready_in}, 32'd0);
    check("clr_async_busy", {31'd0, ifc.busy}, 32'd0);
    check("clr_async_valid", {31'd0, ifc.module_data_in_valid}, 32'd0);
    check("clr_async_data", ifc.module_data_in, 32'd0);
    sb.delete();
    @(negedge clock);
    clear = 1'b0;
    base = pulse_count;
    check("clr_release_ready", {31'd0, ifc.ready_in}, 32'd0);
    man_mr = 1'b1;
    @(negedge clock);
    man_mr = 1'b0;
    check("clr_ready_rise", {31'd0, ifc.ready_in}, 32'd1);
    repeat (5) @(negedge clock);
    check("clr_no_pulse", pulse_count - base, 32'd0);
    check("clr_idle", {31'd0, ifc.busy}, 32'd0);
    auto_en = 1'b1;
    ready_delay = 1;
    drive_word(8'h33);
    wait_idle();
    check("clr_new_word", pulse_count - base, 32'd1);

    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
